// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave response multiplexer: tracks the data-phase owner and steers ready, response
// and read data back to the master, with a built-in default slave for unmapped transfers.
module ahblite_slave_mux #(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [2:0] {DselNone, DselP0, DselP1, DselP2, DselP3, DselDef} dsel_e;
  typedef enum logic [1:0] {DsIdle, DsErr1, DsErr2} ds_e;

  dsel_e      dsel_q, dsel_d;
  ds_e        ds_q, ds_d;
  logic [3:0] sel;
  logic       unused_htrans;

  // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
  assign unused_htrans = HTRANS[0];

  assign sel = {P3_HSEL & Port3_en, P2_HSEL & Port2_en, P1_HSEL & Port1_en, P0_HSEL & Port0_en};

  // Address phase is sampled only when the current data phase completes.
  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) begin
      if (sel[0])         dsel_d = DselP0;
      else if (sel[1])    dsel_d = DselP1;
      else if (sel[2])    dsel_d = DselP2;
      else if (sel[3])    dsel_d = DselP3;
      else if (HTRANS[1]) dsel_d = DselDef;
      else                dsel_d = DselNone;
    end
  end

  always_comb begin
    ds_d = ds_q;
    unique case (ds_q)
      DsIdle:  if (HREADY && (dsel_d == DselDef)) ds_d = DsErr1;
      DsErr1:  ds_d = DsErr2;
      DsErr2:  ds_d = (dsel_d == DselDef) ? DsErr1 : DsIdle;
      default: ds_d = DsIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= DselNone;
      ds_q   <= DsIdle;
    end else begin
      dsel_q <= dsel_d;
      ds_q   <= ds_d;
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    unique case (dsel_q)
      DselP0: begin
        HREADY = P0_HREADYOUT;
        HRESP  = P0_HRESP;
        HRDATA = P0_HRDATA;
      end
      DselP1: begin
        HREADY = P1_HREADYOUT;
        HRESP  = P1_HRESP;
        HRDATA = P1_HRDATA;
      end
      DselP2: begin
        HREADY = P2_HREADYOUT;
        HRESP  = P2_HRESP;
        HRDATA = P2_HRDATA;
      end
      DselP3: begin
        HREADY = P3_HREADYOUT;
        HRESP  = P3_HRESP;
        HRDATA = P3_HRDATA;
      end
      DselDef: begin
        // Two-cycle ERROR: low-ready first cycle, high-ready second.
        HREADY = (ds_q != DsErr1);
        HRESP  = (ds_q != DsIdle);
      end
      default: begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Scoreboard bench: two mux instances (all ports enabled / port 2 disabled) share stimulus;
// expected responses are queued per cycle and checked by an independent monitor.
module tb_ahblite_slave_mux;

  logic        hclk;
  logic        hresetn;
  logic [3:0]  hsel;
  logic [1:0]  htrans;
  logic [3:0]  hreadyout;
  logic [3:0]  sresp;
  logic [31:0] d0, d1, d2, d3;
  logic        rdy_a, resp_a, rdy_b, resp_b;
  logic [31:0] data_a, data_b;

  typedef struct {
    bit          which;
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  localparam logic [1:0] Idle = 2'b00, Busy = 2'b01, Nonseq = 2'b10, Seq = 2'b11;
  localparam logic [31:0] D0 = 32'h0000_1111, D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'h2222_2222, D3 = 32'h3333_3333;

  ahblite_slave_mux dut_a (
    .HCLK(hclk), .HRESETn(hresetn),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
    .HTRANS(htrans),
    .P0_HREADYOUT(hreadyout[0]), .P1_HREADYOUT(hreadyout[1]),
    .P2_HREADYOUT(hreadyout[2]), .P3_HREADYOUT(hreadyout[3]),
    .P0_HRESP(sresp[0]), .P1_HRESP(sresp[1]), .P2_HRESP(sresp[2]), .P3_HRESP(sresp[3]),
    .P0_HRDATA(d0), .P1_HRDATA(d1), .P2_HRDATA(d2), .P3_HRDATA(d3),
    .HREADY(rdy_a), .HRESP(resp_a), .HRDATA(data_a)
  );

  ahblite_slave_mux #(.Port2_en(1'b0)) dut_b (
    .HCLK(hclk), .HRESETn(hresetn),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
    .HTRANS(htrans),
    .P0_HREADYOUT(hreadyout[0]), .P1_HREADYOUT(hreadyout[1]),
    .P2_HREADYOUT(hreadyout[2]), .P3_HREADYOUT(hreadyout[3]),
    .P0_HRESP(sresp[0]), .P1_HRESP(sresp[1]), .P2_HRESP(sresp[2]), .P3_HRESP(sresp[3]),
    .P0_HRDATA(d0), .P1_HRDATA(d1), .P2_HRDATA(d2), .P3_HRDATA(d3),
    .HREADY(rdy_b), .HRESP(resp_b), .HRDATA(data_b)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Monitor: outputs sampled mid-cycle, away from the rising edge.
  always @(negedge hclk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic        r, s;
      logic [31:0] d;
      e = q.pop_front();
      if (e.which) begin r = rdy_b; s = resp_b; d = data_b; end
      else begin r = rdy_a; s = resp_a; d = data_a; end
      checks++;
      if (r === e.rdy && s === e.resp && d === e.data) passed++;
      else $display("FAIL %s dut_%s: got rdy=%b resp=%b data=%h, expected rdy=%b resp=%b data=%h",
                    e.name, e.which ? "b" : "a", r, s, d, e.rdy, e.resp, e.data);
    end
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_in();
    hsel      = 4'b0000;
    htrans    = Idle;
    hreadyout = 4'b1111;
    sresp     = 4'b0000;
  endtask

  task automatic exp1(bit w, string n, logic r, logic s, logic [31:0] d);
    exp_t e;
    e.which = w; e.rdy = r; e.resp = s; e.data = d; e.name = n;
    q.push_back(e);
  endtask

  task automatic exp2(string n, logic r, logic s, logic [31:0] d);
    exp1(1'b0, n, r, s, d);
    exp1(1'b1, n, r, s, d);
  endtask

  initial begin
    d0 = D0; d1 = D1; d2 = D2; d3 = D3;
    hresetn = 1'b0;
    idle_in();

    // Reset and idle bus
    step(); exp2("in_reset", 1'b1, 1'b0, 32'h0);
    step(); exp2("in_reset2", 1'b1, 1'b0, 32'h0);
    step(); hresetn = 1'b1; exp2("reset_release", 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); exp2("idle_okay", 1'b1, 1'b0, 32'h0);
    end

    // P1 read with two wait states; a pending P3 address must not be sampled meanwhile
    step(); htrans = Nonseq; hsel = 4'b0010; exp2("p1_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); hreadyout[1] = 1'b0; exp2("p1_wait1", 1'b0, 1'b0, D1);
    step(); htrans = Nonseq; hsel = 4'b1000; exp2("p1_wait2", 1'b0, 1'b0, D1);
    step(); hreadyout[1] = 1'b1; exp2("p1_ready", 1'b1, 1'b0, D1);
    step(); idle_in(); exp2("p3_data", 1'b1, 1'b0, D3);
    step(); exp2("after_p3", 1'b1, 1'b0, 32'h0);

    // P0 ERROR forwarded unmodified
    step(); htrans = Nonseq; hsel = 4'b0001; exp2("p0_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); hreadyout[0] = 1'b0; sresp[0] = 1'b1; exp2("p0_err1", 1'b0, 1'b1, D0);
    step(); hreadyout[0] = 1'b1; exp2("p0_err2", 1'b1, 1'b1, D0);
    step(); idle_in(); exp2("after_p0", 1'b1, 1'b0, 32'h0);

    // Single unmapped NONSEQ
    step(); htrans = Nonseq; exp2("unm_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); exp2("unm_err1", 1'b0, 1'b1, 32'h0);
    step(); exp2("unm_err2", 1'b1, 1'b1, 32'h0);
    step(); exp2("unm_after", 1'b1, 1'b0, 32'h0);

    // Back-to-back unmapped NONSEQ
    step(); htrans = Nonseq; exp2("b2b_addr", 1'b1, 1'b0, 32'h0);
    step(); exp2("b2b_err1a", 1'b0, 1'b1, 32'h0);
    step(); exp2("b2b_err2a", 1'b1, 1'b1, 32'h0);
    step(); idle_in(); exp2("b2b_err1b", 1'b0, 1'b1, 32'h0);
    step(); exp2("b2b_err2b", 1'b1, 1'b1, 32'h0);
    step(); exp2("b2b_after", 1'b1, 1'b0, 32'h0);

    // P2 select: routed in dut_a, default-slave ERROR in dut_b
    step(); htrans = Nonseq; hsel = 4'b0100; exp2("p2_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in();
    exp1(1'b0, "p2_data", 1'b1, 1'b0, D2);
    exp1(1'b1, "p2_dis_err1", 1'b0, 1'b1, 32'h0);
    step();
    exp1(1'b0, "p2_after", 1'b1, 1'b0, 32'h0);
    exp1(1'b1, "p2_dis_err2", 1'b1, 1'b1, 32'h0);
    step(); exp2("p2_done", 1'b1, 1'b0, 32'h0);

    // Priority: lowest enabled index wins
    step(); htrans = Nonseq; hsel = 4'b1010; exp2("prio13_addr", 1'b1, 1'b0, 32'h0);
    step(); htrans = Nonseq; hsel = 4'b1100; exp2("prio13_data", 1'b1, 1'b0, D1);
    step(); idle_in();
    exp1(1'b0, "prio23_data", 1'b1, 1'b0, D2);
    exp1(1'b1, "prio23_data", 1'b1, 1'b0, D3);
    step(); exp2("prio_after", 1'b1, 1'b0, 32'h0);

    // BUSY unmapped is OKAY; SEQ unmapped is ERROR
    step(); htrans = Busy; exp2("busy_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); exp2("busy_okay", 1'b1, 1'b0, 32'h0);
    step(); htrans = Seq; exp2("seq_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); exp2("seq_err1", 1'b0, 1'b1, 32'h0);
    step(); exp2("seq_err2", 1'b1, 1'b1, 32'h0);
    step(); exp2("seq_after", 1'b1, 1'b0, 32'h0);

    // Asynchronous reset during a P0 wait state
    step(); htrans = Nonseq; hsel = 4'b0001; exp2("rst_p0_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); hreadyout[0] = 1'b0; exp2("rst_p0_wait", 1'b0, 1'b0, D0);
    step(); #2 hresetn = 1'b0; exp2("rst_async", 1'b1, 1'b0, 32'h0);
    step(); exp2("rst_hold", 1'b1, 1'b0, 32'h0);
    step(); hresetn = 1'b1; exp2("rst_rel_wait", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); exp2("rst_rel_idle", 1'b1, 1'b0, 32'h0);

    // Reset in the middle of a default-slave ERROR
    step(); htrans = Nonseq; exp2("rst_err_addr", 1'b1, 1'b0, 32'h0);
    step(); idle_in(); exp2("rst_err1", 1'b0, 1'b1, 32'h0);
    @(negedge hclk); #1 hresetn = 1'b0;
    step(); exp2("rst_err_abort", 1'b1, 1'b0, 32'h0);
    step(); hresetn = 1'b1; exp2("rst_err_rel", 1'b1, 1'b0, 32'h0);
    step(); exp2("rst_err_okay", 1'b1, 1'b0, 32'h0);

    @(negedge hclk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahblite_slave_mux.md
AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

Interface
REQ-001 Parameter Port0_en, default 1, enables port 0 (RAMCODE); 0 means its select is ignored.
REQ-002 Parameter Port1_en, default 1, enables port 1 (RAMDATA).
REQ-003 Parameter Port2_en, default 1, enables port 2 (AHB bridge base).
REQ-004 Parameter Port3_en, default 1, enables port 3 (APB bridge base).
REQ-005 HCLK  input  1  the one clock; all state on rising edge.
REQ-006 HRESETn  input  1  reset, asynchronous, active-low.
REQ-007 P0_HSEL..P3_HSEL  input  1 each  address-phase selects from the address decoder.
REQ-008 HTRANS  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-009 P0_HREADYOUT..P3_HREADYOUT  input  1 each  slave ready.
REQ-010 P0_HRESP..P3_HRESP  input  1 each  slave response (0 OKAY, 1 ERROR).
REQ-011 P0_HRDATA..P3_HRDATA  input  32 each  slave read data.
REQ-012 HREADY  output  1  muxed ready to master and fed back to all slaves.
REQ-013 HRESP  output  1  muxed response to master.
REQ-014 HRDATA  output  32  muxed read data to master.

Function
REQ-015 Effective select Sn = Pn_HSEL AND Portn_en; if several are high, lowest index wins.
REQ-016 "Active" transfer = HTRANS[1]==1 (NONSEQ or SEQ).
REQ-017 Data-phase select register DSEL holds one of {NONE, P0, P1, P2, P3, DEF}.
REQ-018 DSEL SHALL update only on rising HCLK with HREADY==1; it holds while HREADY==0.
REQ-019 Update value: winning Pn if any Sn high; else DEF if transfer active; else NONE.
REQ-020 DSEL==Pn: HREADY=Pn_HREADYOUT, HRESP=Pn_HRESP, HRDATA=Pn_HRDATA, combinationally, zero added latency.
REQ-021 DSEL==NONE: HREADY=1, HRESP=0, HRDATA=0 (IDLE/BUSY to any address, unmapped or not, gets zero-wait OKAY).
REQ-022 Default slave FSM states DS_IDLE, DS_ERR1, DS_ERR2; HRDATA=0 in all DEF cycles.
REQ-023 DS_IDLE -> DS_ERR1 on the edge where DSEL loads DEF.
REQ-024 DS_ERR1: HREADY=0, HRESP=1; unconditionally -> DS_ERR2 next cycle.
REQ-025 DS_ERR2: HREADY=1, HRESP=1; next cycle -> DS_ERR1 if DSEL reloads DEF, else DS_IDLE.
REQ-026 Error response is exactly two cycles per unmapped active transfer; back-to-back unmapped transfers give repeated ERR1/ERR2 pairs with no OKAY gap.
REQ-027 Slave wait states: while HREADY==0 from Pn, new HSEL/HTRANS values are not sampled; DSEL and FSM unchanged.
REQ-028 An enabled port's HRESP=1 is forwarded unmodified; the mux never converts slave responses.
REQ-029 Disabled port addresses with active HTRANS route to DEF and receive the two-cycle ERROR.

Reset
REQ-030 HRESETn low SHALL immediately set DSEL=NONE and FSM=DS_IDLE, asynchronously.
REQ-031 During and right after reset: HREADY=1, HRESP=0, HRDATA=0.
REQ-032 Reset asserted mid-wait-state or mid-ERROR aborts it; first cycle after release is NONE-state OKAY.
REQ-033 Reset release is sampled synchronously; first update occurs on the first HCLK edge with HRESETn high.

Verification
REQ-034 Reset then HTRANS=IDLE, no HSEL -> HREADY=1, HRESP=0, HRDATA=0x00000000 every cycle.
REQ-035 NONSEQ with P1_HSEL=1, P1_HRDATA=0xDEADBEEF, P1_HREADYOUT low 2 cycles -> HREADY 0,0,1 and HRDATA=0xDEADBEEF at the ready cycle; DSEL held P1 throughout.
REQ-036 NONSEQ to unmapped 0x30000000 (no HSEL) -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY.
REQ-037 Two consecutive unmapped NONSEQ transfers -> ERR1,ERR2,ERR1,ERR2 then DS_IDLE.
REQ-038 Port2_en=0, NONSEQ with P2_HSEL=1 -> two-cycle ERROR; P2_HRDATA never visible on HRDATA.
REQ-039 HRESETn pulsed low during P0 wait state (P0_HREADYOUT=0) -> HREADY=1, HRESP=0 immediately, before next HCLK edge.
